// File: rtl/mem_pkg.sv
// Shared constants for the four-bank main memory behind the cache controller.
package mem_pkg;

    localparam int DATA_W       = 16;  // word width
    localparam int ADDR_W       = 16;  // byte address width
    localparam int BANK_CYCLES  = 4;   // cycles a bank stays occupied, issue cycle included
    localparam int RD_LAT       = 2;   // accepted read to data_out valid
    localparam int NUM_BANKS    = 4;   // interleaved banks
    localparam int BANK_SEL_LSB = 1;   // addr[2:1] selects the bank
    localparam int BANK_SEL_W   = 2;   // log2(NUM_BANKS)
    localparam int BUSY_CNT_W   = $clog2(BANK_CYCLES);

endpackage

// File: rtl/mem_bank.sv
// One memory bank: word array, occupancy counter and fixed-latency read pipeline.
module mem_bank
    import mem_pkg::*;
#(
    parameter int DATA_W      = mem_pkg::DATA_W,
    parameter int IDX_W       = mem_pkg::ADDR_W - 3,
    parameter int BANK_CYCLES = mem_pkg::BANK_CYCLES,
    parameter int RD_LAT      = mem_pkg::RD_LAT
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              acc_i,      // request accepted by this bank this cycle
    input  logic              wr_i,       // accepted request is a write
    input  logic [IDX_W-1:0]  idx_i,      // word index within the bank
    input  logic [DATA_W-1:0] wdata_i,
    output logic              busy_o,
    output logic [DATA_W-1:0] rdata_o,    // zero whenever rd_valid_o is low
    output logic              rd_valid_o
);

    localparam int DEPTH = 1 << IDX_W;
    localparam int CNT_W = $clog2(BANK_CYCLES);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              busy_q;
    logic              rd_acc_s;
    logic [RD_LAT-1:0] vld_q, vld_d;
    logic [DATA_W-1:0] dat_q [RD_LAT];
    logic [DATA_W-1:0] dat_d [RD_LAT];

    // Array write; contents survive reset so committed writes are kept.
    always_ff @(posedge clk_i) begin
        if (acc_i && wr_i) begin
            mem_q[idx_i] <= wdata_i;
        end
    end

    // Occupancy counter next state: reload on accept, otherwise count down to zero.
    always_comb begin
        cnt_d = cnt_q;
        if (acc_i) begin
            cnt_d = CNT_W'(BANK_CYCLES - 1);
        end else if (cnt_q != {CNT_W{1'b0}}) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Occupancy counter and registered busy flag tracking it.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q  <= {CNT_W{1'b0}};
            busy_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            busy_q <= (cnt_d != {CNT_W{1'b0}});
        end
    end

    assign rd_acc_s = acc_i & ~wr_i;

    // Read pipeline next state: stage 0 samples the array, later stages shift; data is zeroed when invalid.
    always_comb begin
        vld_d    = {RD_LAT{1'b0}};
        vld_d[0] = rd_acc_s;
        dat_d[0] = rd_acc_s ? mem_q[idx_i] : {DATA_W{1'b0}};
        for (int i = 1; i < RD_LAT; i++) begin
            vld_d[i] = vld_q[i-1];
            dat_d[i] = dat_q[i-1];
        end
    end

    // Read pipeline registers; reset drops any read in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            vld_q <= {RD_LAT{1'b0}};
            for (int i = 0; i < RD_LAT; i++) begin
                dat_q[i] <= {DATA_W{1'b0}};
            end
        end else begin
            vld_q <= vld_d;
            for (int i = 0; i < RD_LAT; i++) begin
                dat_q[i] <= dat_d[i];
            end
        end
    end

    assign busy_o     = busy_q;
    assign rd_valid_o = vld_q[RD_LAT-1];
    assign rdata_o    = dat_q[RD_LAT-1];

endmodule

// File: rtl/four_bank_mem.sv
// Four-bank interleaved main memory: bank decode, legality/stall/err and output merge.
module four_bank_mem
    import mem_pkg::*;
#(
    parameter int DATA_W      = mem_pkg::DATA_W,
    parameter int ADDR_W      = mem_pkg::ADDR_W,
    parameter int BANK_CYCLES = mem_pkg::BANK_CYCLES,
    parameter int RD_LAT      = mem_pkg::RD_LAT
) (
    input  logic                 clk,
    input  logic                 rst,        // asynchronous, active-low
    input  logic [ADDR_W-1:0]    addr,
    input  logic [DATA_W-1:0]    data_in,
    input  logic                 wr,
    input  logic                 rd,
    output logic [DATA_W-1:0]    data_out,
    output logic                 rd_valid,
    output logic                 stall,
    output logic [NUM_BANKS-1:0] busy,
    output logic                 err
);

    localparam int IDX_W = ADDR_W - 3;

    logic                  req_s;
    logic                  legal_s;
    logic [BANK_SEL_W-1:0] bank_s;
    logic [IDX_W-1:0]      idx_s;
    logic [NUM_BANKS-1:0]  busy_s;
    logic [NUM_BANKS-1:0]  acc_s;
    logic [NUM_BANKS-1:0]  vld_s;
    logic [DATA_W-1:0]     rdata_s [NUM_BANKS];

    // Request decode: legality, target bank, and accept/stall/err; requests see only registered busy.
    always_comb begin
        req_s   = rd | wr;
        legal_s = (rd ^ wr) & ~addr[0];
        bank_s  = addr[BANK_SEL_LSB +: BANK_SEL_W];
        idx_s   = addr[ADDR_W-1:3];
        acc_s   = {NUM_BANKS{1'b0}};
        for (int i = 0; i < NUM_BANKS; i++) begin
            if (legal_s && !busy_s[i] && (bank_s == BANK_SEL_W'(i))) begin
                acc_s[i] = 1'b1;
            end else begin
                acc_s[i] = 1'b0;
            end
        end
        stall = legal_s & busy_s[bank_s];
        err   = req_s & ~legal_s;
    end

    for (genvar g = 0; g < NUM_BANKS; g++) begin : g_bank
        mem_bank #(
            .DATA_W      (DATA_W),
            .IDX_W       (IDX_W),
            .BANK_CYCLES (BANK_CYCLES),
            .RD_LAT      (RD_LAT)
        ) u_bank (
            .clk_i      (clk),
            .rst_ni     (rst),
            .acc_i      (acc_s[g]),
            .wr_i       (wr),
            .idx_i      (idx_s),
            .wdata_i    (data_in),
            .busy_o     (busy_s[g]),
            .rdata_o    (rdata_s[g]),
            .rd_valid_o (vld_s[g])
        );
    end

    // Merge bank read ports; single-port issue means at most one bank is valid, and idle banks drive zero.
    always_comb begin
        data_out = {DATA_W{1'b0}};
        rd_valid = 1'b0;
        for (int i = 0; i < NUM_BANKS; i++) begin
            data_out = data_out | rdata_s[i];
            rd_valid = rd_valid | vld_s[i];
        end
    end

    assign busy = busy_s;

endmodule
